// File: rtl/mtimer.sv
// mtimer: machine timer (mtime/mtimecmp) and software interrupt source behind a 32-bit request/response port
//   clk_i, rst_i               : core clock, asynchronous active-high reset
//   req_valid_i/req_ready_o    : request handshake
//   req_we_i, req_addr_i       : write enable, byte offset ([1:0] ignored)
//   req_wdata_i, req_wstrb_i   : write data and byte enables
//   resp_valid_o/resp_ready_i  : response handshake
//   resp_rdata_o, resp_err_o   : read data (0 for writes/errors), unmapped-offset flag
//   mtip_o, msip_o             : level-sensitive timer and software interrupt lines
module mtimer #(
   parameter int unsigned PrescaleDiv = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [4:0]  req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [3:0]  req_wstrb_i,
   output logic        resp_valid_o,
   input  logic        resp_ready_i,
   output logic [31:0] resp_rdata_o,
   output logic        resp_err_o,
   output logic        mtip_o,
   output logic        msip_o
);
   logic [63:0] r_mtime, r_mtimecmp;
   logic [15:0] r_presc;
   logic        r_en, r_msip, r_mtip, r_resp_valid, r_resp_err;
   logic [31:0] r_resp_rdata;
   logic [2:0]  w_idx;
   logic        w_acc, w_err, w_wr, w_tick, w_unused;
   logic [31:0] w_bmask, w_rdata;

   function automatic logic [31:0] f_merge(input logic [31:0] old, input logic [31:0] wd, input logic [31:0] m);
      return (old & ~m) | (wd & m);
   endfunction

   assign w_unused     = ^req_addr_i[1:0];
   assign w_idx        = req_addr_i[4:2];
   assign req_ready_o  = !r_resp_valid || resp_ready_i;
   assign w_acc        = req_valid_i && req_ready_o;
   assign w_err        = w_idx[2] && w_idx[1];
   assign w_wr         = w_acc && req_we_i && !w_err;
   assign w_tick       = r_en && (r_presc == 16'(PrescaleDiv - 1));
   assign w_bmask      = {{8{req_wstrb_i[3]}}, {8{req_wstrb_i[2]}}, {8{req_wstrb_i[1]}}, {8{req_wstrb_i[0]}}};
   assign w_rdata      = w_idx == 3'd0 ? r_mtime[31:0]     :
                         w_idx == 3'd1 ? r_mtime[63:32]    :
                         w_idx == 3'd2 ? r_mtimecmp[31:0]  :
                         w_idx == 3'd3 ? r_mtimecmp[63:32] :
                         w_idx == 3'd4 ? {31'd0, r_en}     :
                         w_idx == 3'd5 ? {31'd0, r_msip}   : 32'd0;
   assign resp_valid_o = r_resp_valid;
   assign resp_rdata_o = r_resp_rdata;
   assign resp_err_o   = r_resp_err;
   assign mtip_o       = r_mtip;
   assign msip_o       = r_msip;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_mtime      <= 64'd0;
         r_mtimecmp   <= '1;
         r_presc      <= 16'd0;
         r_en         <= 1'b1;
         r_msip       <= 1'b0;
         r_mtip       <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= 32'd0;
         r_resp_err   <= 1'b0;
      end else begin
         if (r_en) r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
         // a write to either mtime half suppresses that cycle's increment entirely
         if (w_wr && w_idx == 3'd0) r_mtime[31:0] <= f_merge(r_mtime[31:0], req_wdata_i, w_bmask);
         else if (w_wr && w_idx == 3'd1) r_mtime[63:32] <= f_merge(r_mtime[63:32], req_wdata_i, w_bmask);
         else if (w_tick) r_mtime <= r_mtime + 64'd1;
         if (w_wr && w_idx == 3'd2) r_mtimecmp[31:0] <= f_merge(r_mtimecmp[31:0], req_wdata_i, w_bmask);
         if (w_wr && w_idx == 3'd3) r_mtimecmp[63:32] <= f_merge(r_mtimecmp[63:32], req_wdata_i, w_bmask);
         if (w_wr && w_idx == 3'd4 && req_wstrb_i[0]) r_en <= req_wdata_i[0];
         if (w_wr && w_idx == 3'd5 && req_wstrb_i[0]) r_msip <= req_wdata_i[0];
         r_mtip <= r_mtime >= r_mtimecmp;
         if (w_acc) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= (req_we_i || w_err) ? 32'd0 : w_rdata;
            r_resp_err   <= w_err;
         end else if (resp_ready_i) r_resp_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mtimer.sv
// tb_mtimer: self-checking bench; instances with PrescaleDiv 1 and 4 share one stimulus stream
module tb_mtimer;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b1;
   logic [4:0]  req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic [3:0]  req_wstrb = '0;
   logic        req_ready [2], resp_valid [2], resp_err [2], mtip [2], msip [2];
   logic [31:0] resp_rdata [2];
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   mtimer #(.PrescaleDiv(1)) u_div1 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready[0]),
      .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
      .resp_valid_o(resp_valid[0]), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata[0]),
      .resp_err_o(resp_err[0]), .mtip_o(mtip[0]), .msip_o(msip[0]));

   mtimer #(.PrescaleDiv(4)) u_div4 (
      .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(req_ready[1]),
      .req_we_i(req_we), .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
      .resp_valid_o(resp_valid[1]), .resp_ready_i(resp_ready), .resp_rdata_o(resp_rdata[1]),
      .resp_err_o(resp_err[1]), .mtip_o(mtip[1]), .msip_o(msip[1]));

   // reference model: the register file as six 32-bit words, plus prescale phase and response state
   logic [31:0] mr [2][6];
   int          mph [2];
   logic        mrv [2], merr [2], mmtip [2];
   logic [31:0] mrd [2];

   typedef struct {
      logic        we;
      logic [4:0]  a;
      logic [31:0] wd;
      logic [3:0]  st;
      logic [31:0] rd;
      logic        err;
      logic        msip;
   } vec_t;
   vec_t tbl [14];

   function automatic int pdiv(input int d);
      return d == 0 ? 1 : 4;
   endfunction

   task automatic chk(input string nm, input int d, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s dut%0d actual=%0h expected=%0h", nm, d, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         mr[d][0] = 32'd0;
         mr[d][1] = 32'd0;
         mr[d][2] = 32'hFFFF_FFFF;
         mr[d][3] = 32'hFFFF_FFFF;
         mr[d][4] = 32'd1;
         mr[d][5] = 32'd0;
         mph[d] = 0;
         mrv[d] = 1'b0;
         merr[d] = 1'b0;
         mmtip[d] = 1'b0;
         mrd[d] = 32'd0;
      end
   endtask

   task automatic check_outs();
      for (int d = 0; d < 2; d++) begin
         chk("req_ready", d, req_ready[d], !mrv[d] || resp_ready);
         chk("resp_valid", d, resp_valid[d], mrv[d]);
         chk("mtip", d, mtip[d], mmtip[d]);
         chk("msip", d, msip[d], mr[d][5][0]);
         if (mrv[d]) begin
            chk("resp_rdata", d, resp_rdata[d], mrd[d]);
            chk("resp_err", d, resp_err[d], merr[d]);
         end
      end
   endtask

   // one clock: predict next state from current inputs, step, then compare
   task automatic cycle();
      logic [31:0] nr [2][6];
      int          nph [2];
      logic        nrv [2], nerr [2], nmtip [2];
      logic [31:0] nrd [2];
      for (int d = 0; d < 2; d++) begin
         int idx;
         bit acc, bad, wr, tick;
         idx = int'(req_addr[4:2]);
         acc = req_valid && (!mrv[d] || resp_ready);
         bad = idx > 5;
         wr  = acc && req_we && !bad;
         for (int i = 0; i < 6; i++) nr[d][i] = mr[d][i];
         nph[d] = mr[d][4][0] ? (mph[d] + 1) % pdiv(d) : mph[d];
         tick = mr[d][4][0] && nph[d] == 0;
         if (wr)
            for (int b = 0; b < 4; b++)
               if (req_wstrb[b]) nr[d][idx][8*b +: 8] = req_wdata[8*b +: 8];
         nr[d][4] &= 32'd1;
         nr[d][5] &= 32'd1;
         if (tick && !(wr && idx < 2)) {nr[d][1], nr[d][0]} = {mr[d][1], mr[d][0]} + 64'd1;
         nmtip[d] = {mr[d][1], mr[d][0]} >= {mr[d][3], mr[d][2]};
         nrv[d]   = acc ? 1'b1 : (resp_ready ? 1'b0 : mrv[d]);
         nrd[d]   = acc ? ((req_we || bad) ? 32'd0 : mr[d][idx]) : mrd[d];
         nerr[d]  = acc ? bad : merr[d];
      end
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 6; i++) mr[d][i] = nr[d][i];
         mph[d] = nph[d];
         mrv[d] = nrv[d];
         mrd[d] = nrd[d];
         merr[d] = nerr[d];
         mmtip[d] = nmtip[d];
      end
      #1;
      check_outs();
   endtask

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) cycle();
   endtask

   task automatic xact(input logic we, input logic [4:0] a, input logic [31:0] wd, input logic [3:0] st);
      int n;
      bit acc;
      n = 0;
      req_valid = 1'b1;
      req_we = we;
      req_addr = a;
      req_wdata = wd;
      req_wstrb = st;
      do begin
         acc = !mrv[0] || resp_ready;
         cycle();
         n++;
      end while (!acc && n < 20);
      if (!acc) begin
         errors++;
         $display("FAIL xact_timeout dut0 actual=no_accept expected=accept");
      end
      req_valid = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{1'b1, 5'h08, 32'h1234_5678, 4'hF, 32'h0,         1'b0, 1'b0};
      tbl[1]  = '{1'b0, 5'h08, 32'h0,         4'h0, 32'h1234_5678, 1'b0, 1'b0};
      tbl[2]  = '{1'b1, 5'h0C, 32'hAABB_CCDD, 4'h5, 32'h0,         1'b0, 1'b0};
      tbl[3]  = '{1'b0, 5'h0C, 32'h0,         4'h0, 32'hFFBB_FFDD, 1'b0, 1'b0};
      tbl[4]  = '{1'b1, 5'h08, 32'hDEAD_BEEF, 4'h0, 32'h0,         1'b0, 1'b0};
      tbl[5]  = '{1'b0, 5'h08, 32'h0,         4'h0, 32'h1234_5678, 1'b0, 1'b0};
      tbl[6]  = '{1'b1, 5'h14, 32'hFFFF_FFFE, 4'hF, 32'h0,         1'b0, 1'b0};
      tbl[7]  = '{1'b0, 5'h14, 32'h0,         4'h0, 32'h0,         1'b0, 1'b0};
      tbl[8]  = '{1'b1, 5'h14, 32'h0000_00AB, 4'h1, 32'h0,         1'b0, 1'b1};
      tbl[9]  = '{1'b0, 5'h14, 32'h0,         4'h0, 32'h1,         1'b0, 1'b1};
      tbl[10] = '{1'b0, 5'h1C, 32'h0,         4'h0, 32'h0,         1'b1, 1'b1};
      tbl[11] = '{1'b1, 5'h18, 32'hFFFF_FFFF, 4'hF, 32'h0,         1'b1, 1'b1};
      tbl[12] = '{1'b0, 5'h10, 32'h0,         4'h0, 32'h1,         1'b0, 1'b1};
      tbl[13] = '{1'b0, 5'h13, 32'h0,         4'h0, 32'h1,         1'b0, 1'b1};

      model_reset();
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("rst_req_ready", d, req_ready[d], 1);
         chk("rst_resp_valid", d, resp_valid[d], 0);
         chk("rst_rdata", d, resp_rdata[d], 0);
         chk("rst_mtip", d, mtip[d], 0);
      end
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check_outs();

      // first ticks: 10 enabled cycles, then read mtime lo
      idle(10);
      xact(1'b0, 5'h00, 32'h0, 4'h0);
      chk("first_ticks", 0, resp_rdata[0], 10);
      chk("first_ticks", 1, resp_rdata[1], 2);

      // register table
      for (int i = 0; i < 14; i++) begin
         xact(tbl[i].we, tbl[i].a, tbl[i].wd, tbl[i].st);
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("tbl%0d_rdata", i), d, resp_rdata[d], tbl[i].rd);
            chk($sformatf("tbl%0d_err", i), d, resp_err[d], tbl[i].err);
            chk($sformatf("tbl%0d_msip", i), d, msip[d], tbl[i].msip);
         end
      end

      // compare crossing
      xact(1'b1, 5'h10, 32'h0, 4'hF);
      xact(1'b1, 5'h00, 32'h0, 4'hF);
      xact(1'b1, 5'h04, 32'h0, 4'hF);
      xact(1'b1, 5'h0C, 32'h0, 4'hF);
      xact(1'b1, 5'h08, 32'd20, 4'hF);
      xact(1'b1, 5'h10, 32'h1, 4'hF);
      idle(20);
      chk("mtip_before_cross", 0, mtip[0], 0);
      idle(1);
      chk("mtip_at_cross", 0, mtip[0], 1);
      idle(100);
      xact(1'b1, 5'h08, 32'hFFFF_FFFF, 4'hF);
      for (int d = 0; d < 2; d++) chk("mtip_hold", d, mtip[d], 1);
      idle(1);
      for (int d = 0; d < 2; d++) chk("mtip_fall", d, mtip[d], 0);
      xact(1'b1, 5'h0C, 32'hFFFF_FFFF, 4'hF);
      idle(3);

      // wrap and write priority
      xact(1'b1, 5'h10, 32'h0, 4'hF);
      xact(1'b1, 5'h00, 32'hFFFF_FFFE, 4'hF);
      xact(1'b1, 5'h04, 32'hFFFF_FFFF, 4'hF);
      xact(1'b1, 5'h10, 32'h1, 4'hF);
      idle(2);
      xact(1'b0, 5'h04, 32'h0, 4'h0);
      chk("wrap_hi", 0, resp_rdata[0], 0);
      xact(1'b0, 5'h00, 32'h0, 4'h0);
      idle(10);
      req_valid = 1'b1; req_we = 1'b1; req_addr = 5'h00; req_wdata = 32'd5; req_wstrb = 4'hF;
      cycle();
      req_we = 1'b0;
      cycle();
      req_valid = 1'b0;
      for (int d = 0; d < 2; d++) chk("write_wins", d, resp_rdata[d], 5);
      idle(2);

      // prescaler and enable
      idle(21);
      xact(1'b1, 5'h10, 32'h0, 4'h1);
      xact(1'b0, 5'h00, 32'h0, 4'h0);
      idle(50);
      xact(1'b0, 5'h00, 32'h0, 4'h0);
      xact(1'b1, 5'h10, 32'h1, 4'h1);
      idle(9);
      xact(1'b0, 5'h00, 32'h0, 4'h0);
      idle(2);

      // bus protocol: stalled response, then back-to-back
      resp_ready = 1'b0;
      xact(1'b0, 5'h08, 32'h0, 4'h0);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 5'h0C;
      repeat (5) begin
         cycle();
         for (int d = 0; d < 2; d++) chk("stall_ready", d, req_ready[d], 0);
      end
      resp_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         req_addr = 5'(i * 4);
         cycle();
         for (int d = 0; d < 2; d++) chk("b2b_valid", d, resp_valid[d], 1);
      end
      idle(2);

      // randomized traffic against the model
      for (int n = 0; n < 3000; n++) begin
         req_valid  = $urandom_range(0, 3) != 0;
         req_we     = 1'($urandom_range(0, 1));
         req_addr   = 5'($urandom);
         req_wdata  = $urandom;
         req_wstrb  = 4'($urandom);
         resp_ready = $urandom_range(0, 3) != 0;
         if (req_addr[4:2] == 3'd1 || req_addr[4:2] == 3'd3) req_wdata = 32'($urandom_range(0, 1));
         if (req_addr[4:2] == 3'd4 && $urandom_range(0, 3) != 0) req_wdata[0] = 1'b1;
         cycle();
      end
      resp_ready = 1'b1;
      idle(3);

      // async reset mid-transaction
      xact(1'b1, 5'h08, 32'h0, 4'hF);
      xact(1'b1, 5'h0C, 32'h0, 4'hF);
      idle(2);
      for (int d = 0; d < 2; d++) chk("pre_rst_mtip", d, mtip[d], 1);
      resp_ready = 1'b0;
      xact(1'b0, 5'h00, 32'h0, 4'h0);
      for (int d = 0; d < 2; d++) chk("pre_rst_valid", d, resp_valid[d], 1);
      #2 rst = 1'b1;
      #1;
      for (int d = 0; d < 2; d++) begin
         chk("arst_req_ready", d, req_ready[d], 1);
         chk("arst_resp_valid", d, resp_valid[d], 0);
         chk("arst_rdata", d, resp_rdata[d], 0);
         chk("arst_err", d, resp_err[d], 0);
         chk("arst_mtip", d, mtip[d], 0);
         chk("arst_msip", d, msip[d], 0);
      end
      model_reset();
      resp_ready = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check_outs();
      for (int i = 2; i < 6; i++) begin
         xact(1'b0, 5'(i * 4), 32'h0, 4'h0);
         chk("post_rst_reg", 0, resp_rdata[0], i < 4 ? 32'hFFFF_FFFF : (i == 4 ? 32'd1 : 32'd0));
      end
      xact(1'b0, 5'h04, 32'h0, 4'h0);
      chk("post_rst_mtime_hi", 0, resp_rdata[0], 0);
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
